// File: rtl/multi_interval_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// bit positions inside STATUS/CONTROL and the VERSION word.
package multi_timer_pkg;

  // Offsets inside a channel bank
  localparam logic [1:0] REG_STATUS     = 2'd0;
  localparam logic [1:0] REG_CONTROL    = 2'd1;
  localparam logic [1:0] REG_PERIOD     = 2'd2;
  localparam logic [1:0] REG_SNAPSHOT   = 2'd3;

  // Offsets inside the global bank
  localparam logic [1:0] REG_PRESCALE   = 2'd0;
  localparam logic [1:0] REG_IRQ_PEND   = 2'd1;
  localparam logic [1:0] REG_START_MASK = 2'd2;
  localparam logic [1:0] REG_VERSION    = 2'd3;

  // STATUS bits
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  // CONTROL bits
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [31:0] VERSION = 32'h0002_0000;

  // The global bank sits directly after the last channel bank.
  function automatic int global_bank(input int num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/multi_interval_timer_if.sv
// Avalon-MM slave bus plus interrupt line of the interval timer.
interface multi_interval_timer_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/multi_interval_timer_channel.sv
// One timer channel: down-counter with reloadable period, one-shot or
// continuous mode, sticky timeout flag and a software-triggered snapshot.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PERIOD = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_status,
  input  logic             wr_ctrl,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic             clr_to,
  input  logic             start_ext,
  input  logic [31:0]      wdata,
  output logic [1:0]       status,
  output logic [1:0]       ctrl,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snapshot,
  output logic             to_irq
);

  logic [CNT_W-1:0] count, count_nx, period_nx, snapshot_nx;
  logic             run, run_nx, to, to_nx;
  logic             cont, cont_nx, ito, ito_nx;
  logic             reload, reload_nx;
  logic             to_event, start, stop, clear;

  assign start  = (wr_ctrl & wdata[CTRL_START]) | start_ext;
  assign stop   = wr_ctrl & wdata[CTRL_STOP];
  assign clear  = wr_status | clr_to;
  assign status = {run, to};
  assign ctrl   = {cont, ito};
  assign to_irq = to & ito;

  // Next-state logic: pending reload beats counting, START beats STOP, and a
  // timeout event beats a simultaneous TO clear.
  always_comb begin
    count_nx    = count;
    period_nx   = period;
    snapshot_nx = snapshot;
    run_nx      = run;
    cont_nx     = cont;
    ito_nx      = ito;
    reload_nx   = 1'b0;
    to_event    = 1'b0;

    if (reload) begin
      count_nx = period;
      run_nx   = 1'b0;
    end else if (tick && run) begin
      if (count == {CNT_W{1'b0}}) begin
        count_nx = period;
        to_event = 1'b1;
        run_nx   = cont;
      end else begin
        count_nx = count - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_nx = count;
    end

    if (wr_period) begin
      period_nx = wdata[CNT_W-1:0];
      reload_nx = 1'b1;
    end else begin
      period_nx = period;
    end

    if (wr_ctrl) begin
      cont_nx = wdata[CTRL_CONT];
      ito_nx  = wdata[CTRL_ITO];
    end else begin
      cont_nx = cont;
      ito_nx  = ito;
    end

    if (wr_snap) begin
      snapshot_nx = count;
    end else begin
      snapshot_nx = snapshot;
    end

    run_nx = start ? 1'b1 : (stop ? 1'b0 : run_nx);
    to_nx  = (to & ~clear) | to_event;
  end

  // Channel state register with asynchronous reset to the documented defaults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= RST_PERIOD;
      period   <= RST_PERIOD;
      snapshot <= {CNT_W{1'b0}};
      run      <= 1'b0;
      to       <= 1'b0;
      cont     <= 1'b0;
      ito      <= 1'b0;
      reload   <= 1'b0;
    end else begin
      count    <= count_nx;
      period   <= period_nx;
      snapshot <= snapshot_nx;
      run      <= run_nx;
      to       <= to_nx;
      cont     <= cont_nx;
      ito      <= ito_nx;
      reload   <= reload_nx;
    end
  end

endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: shared prescaler, address decode,
// NUM_CH timer channels, registered read mux and combined IRQ.
module multi_interval_timer
  import multi_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] RST_PERIOD = 32'h0000_C34F,
  parameter int          ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_interval_timer_if.slave bus
);

  localparam int GBANK = global_bank(NUM_CH);

  logic [ADDR_W-3:0]     bank;
  logic [1:0]            regsel;
  logic                  wr, glob, wr_pre, wr_pend, wr_mask, tick;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [NUM_CH-1:0]     ch_irq;
  logic [31:0]           ch_word [NUM_CH];
  logic [31:0]           rd_ch, rd_glob, rd_next;

  assign bank    = bus.address[ADDR_W-1:2];
  assign regsel  = bus.address[1:0];
  assign wr      = bus.chipselect & ~bus.write_n;
  assign glob    = (int'(bank) == GBANK);
  assign wr_pre  = wr & glob & (regsel == REG_PRESCALE);
  assign wr_pend = wr & glob & (regsel == REG_IRQ_PEND);
  assign wr_mask = wr & glob & (regsel == REG_START_MASK);
  assign tick    = (pcnt == prescale);
  assign bus.irq = |ch_irq;

  // Prescaler: free-running, wraps after reaching PRESCALE; a PRESCALE write restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= {PRESCALE_W{1'b0}};
      pcnt     <= {PRESCALE_W{1'b0}};
    end else if (wr_pre) begin
      prescale <= bus.writedata[PRESCALE_W-1:0];
      pcnt     <= {PRESCALE_W{1'b0}};
    end else if (tick) begin
      pcnt     <= {PRESCALE_W{1'b0}};
    end else begin
      pcnt     <= pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             sel;
    logic [1:0]       status, ctrl;
    logic [CNT_W-1:0] period, snapshot;
    logic [31:0]      word;

    assign sel = wr & (int'(bank) == g);

    timer_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD[CNT_W-1:0])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .wr_status (sel & (regsel == REG_STATUS)),
      .wr_ctrl   (sel & (regsel == REG_CONTROL)),
      .wr_period (sel & (regsel == REG_PERIOD)),
      .wr_snap   (sel & (regsel == REG_SNAPSHOT)),
      .clr_to    (wr_pend & bus.writedata[g]),
      .start_ext (wr_mask & bus.writedata[g]),
      .wdata     (bus.writedata),
      .status    (status),
      .ctrl      (ctrl),
      .period    (period),
      .snapshot  (snapshot),
      .to_irq    (ch_irq[g])
    );

    // Per-channel register view selected by the low address bits.
    always_comb begin
      word = 32'd0;
      case (regsel)
        REG_STATUS:   word = 32'(status);
        REG_CONTROL:  word = 32'(ctrl);
        REG_PERIOD:   word = 32'(period);
        REG_SNAPSHOT: word = 32'(snapshot);
        default:      word = 32'd0;
      endcase
    end

    assign ch_word[g] = word;
  end

  // Read mux: channel banks, global bank, zero for unmapped banks.
  always_comb begin
    rd_ch = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = rd_ch | ((int'(bank) == c) ? ch_word[c] : 32'd0);
    end
    rd_glob = 32'd0;
    case (regsel)
      REG_PRESCALE:   rd_glob = 32'(prescale);
      REG_IRQ_PEND:   rd_glob = 32'(ch_irq);
      REG_START_MASK: rd_glob = 32'd0;
      REG_VERSION:    rd_glob = VERSION;
      default:        rd_glob = 32'd0;
    endcase
    if (glob) begin
      rd_next = rd_glob;
    end else begin
      rd_next = rd_ch;
    end
  end

  // Registered read data, one cycle after the address is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Self-checking bench for multi_interval_timer: directed scenarios plus
// randomized bus traffic, all compared against a behavioural model.
module tb_multi_interval_timer;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  multi_interval_timer_if #(.ADDR_W(5)) bus ();

  multi_interval_timer #(
    .NUM_CH(4), .CNT_W(32), .PRESCALE_W(16),
    .RST_PERIOD(32'h0000_C34F), .ADDR_W(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model state
  logic [31:0] m_count [NCH];
  logic [31:0] m_period[NCH];
  logic [31:0] m_snap  [NCH];
  logic        m_run   [NCH];
  logic        m_to    [NCH];
  logic        m_cont  [NCH];
  logic        m_ito   [NCH];
  logic        m_reload[NCH];
  logic [15:0] m_pre, m_pcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_count[c] = 32'h0000_C34F; m_period[c] = 32'h0000_C34F; m_snap[c] = 32'd0;
      m_run[c] = 1'b0; m_to[c] = 1'b0; m_cont[c] = 1'b0; m_ito[c] = 1'b0; m_reload[c] = 1'b0;
    end
    m_pre = 16'd0; m_pcnt = 16'd0;
  endtask

  function automatic logic [31:0] m_irq_pend();
    logic [31:0] v;
    v = 32'd0;
    for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int b, r;
    b = int'(a[4:2]); r = int'(a[1:0]);
    if (b < NCH) begin
      case (r)
        0: return {30'd0, m_run[b], m_to[b]};
        1: return {30'd0, m_cont[b], m_ito[b]};
        2: return m_period[b];
        default: return m_snap[b];
      endcase
    end else if (b == NCH) begin
      case (r)
        0: return {16'd0, m_pre};
        1: return m_irq_pend();
        2: return 32'd0;
        default: return 32'h0002_0000;
      endcase
    end
    return 32'd0;
  endfunction

  // One clock of the timer rules applied to the model.
  task automatic model_step(input logic wr, input logic [4:0] a, input logic [31:0] d);
    logic tick, ev, start, stop, clr;
    logic [31:0] old_count;
    int b, r;
    b = int'(a[4:2]); r = int'(a[1:0]);
    tick = (m_pcnt == m_pre);
    for (int c = 0; c < NCH; c++) begin
      old_count = m_count[c];
      ev = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
      if (m_reload[c]) begin
        m_count[c] = m_period[c]; m_run[c] = 1'b0; m_reload[c] = 1'b0;
      end else if (tick && m_run[c]) begin
        if (m_count[c] == 32'd0) begin
          m_count[c] = m_period[c]; ev = 1'b1; m_run[c] = m_cont[c];
        end else begin
          m_count[c] = m_count[c] - 32'd1;
        end
      end
      if (wr && b == c) begin
        case (r)
          0: clr = 1'b1;
          1: begin m_cont[c] = d[1]; m_ito[c] = d[0]; start = d[2]; stop = d[3]; end
          2: begin m_period[c] = d; m_reload[c] = 1'b1; end
          default: m_snap[c] = old_count;
        endcase
      end
      if (wr && b == NCH && r == 1 && d[c]) clr = 1'b1;
      if (wr && b == NCH && r == 2 && d[c]) start = 1'b1;
      if (start) m_run[c] = 1'b1;
      else if (stop) m_run[c] = 1'b0;
      m_to[c] = (m_to[c] & ~clr) | ev;
    end
    if (wr && b == NCH && r == 0) begin
      m_pre = d[15:0]; m_pcnt = 16'd0;
    end else begin
      m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    end
  endtask

  // Drive one bus cycle, advance the model, compare readdata and irq.
  task automatic do_cycle(input logic cs, input logic wn, input logic [4:0] a,
                          input logic [31:0] d, input string tag);
    logic [31:0] exp_rd;
    logic        exp_irq;
    @(negedge clk);
    bus.chipselect = cs; bus.write_n = wn; bus.address = a; bus.writedata = d;
    exp_rd = m_read(a);
    model_step(cs && !wn, a, d);
    exp_irq = |m_irq_pend();
    @(posedge clk);
    #1;
    cyc++;
    check_val({tag, "_rd"}, bus.readdata, exp_rd);
    check_val({tag, "_irq"}, {31'd0, bus.irq}, {31'd0, exp_irq});
  endtask

  task automatic wr_reg(input int b, input int r, input logic [31:0] d);
    do_cycle(1'b1, 1'b0, 5'(b * 4 + r), d, "wr");
  endtask

  task automatic rd_reg(input int b, input int r, output logic [31:0] v);
    do_cycle(1'b1, 1'b1, 5'(b * 4 + r), 32'd0, "rd");
    v = bus.readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, 5'd0, 32'd0, "idle");
  endtask

  task automatic wait_irq(input int budget);
    for (int i = 0; i < budget && !bus.irq; i++) idle(1);
  endtask

  task automatic reset_scan(input string tag);
    logic [31:0] v, e;
    for (int a = 0; a < 24; a++) begin
      do_cycle(1'b1, 1'b1, 5'(a), 32'd0, tag);
      v = bus.readdata;
      e = (a < 16 && a % 4 == 2) ? 32'h0000_C34F : ((a == 19) ? 32'h0002_0000 : 32'd0);
      check_val(tag, v, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int t0, t1, t2;
    int op, b, r;
    logic [31:0] d;

    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 5'd0; bus.writedata = 32'd0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_rd", bus.readdata, 32'd0);
    check_val("reset_irq", {31'd0, bus.irq}, 32'd0);
    reset = 1'b0;
    reset_scan("reset_scan");

    // Channel 0: period 9, continuous, interrupt every 10 clocks
    wr_reg(0, 2, 32'd9);
    wr_reg(0, 1, 32'h7);
    t0 = cyc;
    wait_irq(40);
    t1 = cyc;
    check_val("ch0_first_to", {31'd0, bus.irq}, 32'd1);
    check_val("ch0_first_dt", 32'(t1 - t0), 32'd10);
    wr_reg(0, 0, 32'd0);
    check_val("ch0_clr_irq", {31'd0, bus.irq}, 32'd0);
    wait_irq(40);
    t2 = cyc;
    check_val("ch0_period_dt", 32'(t2 - t1), 32'd10);
    wr_reg(0, 1, 32'h8);
    wr_reg(0, 0, 32'd0);

    // Channel 1: period 4, prescale 3, one-shot
    wr_reg(1, 2, 32'd4);
    idle(1);
    wr_reg(4, 0, 32'd3);
    wr_reg(1, 1, 32'h4);
    idle(18);
    rd_reg(1, 0, v);
    check_val("ch1_running", v, 32'h2);
    rd_reg(1, 0, v);
    check_val("ch1_oneshot_to", v, 32'h1);
    wr_reg(1, 3, 32'd0);
    rd_reg(1, 3, v);
    check_val("ch1_reloaded", v, 32'd4);
    wr_reg(4, 0, 32'd0);
    wr_reg(1, 0, 32'd0);

    // Synchronized start of all channels
    for (int c = 0; c < NCH; c++) wr_reg(c, 2, 32'd5);
    idle(1);
    for (int c = 0; c < NCH; c++) wr_reg(c, 1, 32'h1);
    wr_reg(4, 2, 32'hF);
    t0 = cyc;
    wait_irq(30);
    check_val("mask_dt", 32'(cyc - t0), 32'd6);
    rd_reg(4, 1, v);
    check_val("mask_all_to", v, 32'hF);
    wr_reg(4, 1, 32'h5);
    rd_reg(4, 1, v);
    check_val("pend_w1c", v, 32'hA);
    wr_reg(4, 1, 32'hA);

    // START and STOP together, then a PERIOD write mid-count
    wr_reg(2, 2, 32'd1000);
    idle(1);
    wr_reg(2, 1, 32'hC);
    idle(5);
    rd_reg(2, 0, v);
    check_val("startstop_run", v, 32'h2);
    wr_reg(2, 2, 32'd77);
    idle(1);
    rd_reg(2, 0, v);
    check_val("period_wr_stops", v, 32'h0);
    wr_reg(2, 3, 32'd0);
    rd_reg(2, 3, v);
    check_val("period_wr_reload", v, 32'd77);

    // Clear in the exact timeout cycle: event wins
    wr_reg(3, 2, 32'd3);
    idle(1);
    wr_reg(3, 1, 32'h4);
    idle(3);
    wr_reg(3, 0, 32'd0);
    rd_reg(3, 0, v);
    check_val("clr_vs_event", v, 32'h1);

    // Period 0 continuous: timeout every tick
    wr_reg(3, 2, 32'd0);
    idle(1);
    wr_reg(3, 1, 32'h7);
    wr_reg(3, 0, 32'd0);
    idle(1);
    rd_reg(3, 0, v);
    check_val("period0_cont", v, 32'h3);
    wr_reg(3, 1, 32'h8);
    wr_reg(3, 0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        idle(1);
      end else if (op < 7) begin
        do_cycle(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, "rnd_rd");
      end else begin
        b = $urandom_range(0, 4);
        r = $urandom_range(0, 3);
        d = $urandom;
        if (b < NCH && r == 2) d = 32'($urandom_range(0, 15));
        if (b == NCH && r == 0) d = 32'($urandom_range(0, 3));
        do_cycle(1'b1, 1'b0, 5'(b * 4 + r), d, "rnd_wr");
      end
    end

    // Asynchronous reset in the middle of counting
    wr_reg(4, 0, 32'd0);
    wr_reg(0, 2, 32'd50);
    idle(1);
    wr_reg(0, 1, 32'h7);
    idle(10);
    rd_reg(4, 3, v);
    check_val("pre_reset_version", v, 32'h0002_0000);
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_rd", bus.readdata, 32'd0);
    check_val("async_reset_irq", {31'd0, bus.irq}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_scan("post_reset_scan");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
